// File: rtl/riser_spi_reply_pkg.sv
// ============================================================================
// Module  : riser_spi_reply_pkg
// Brief   : Shared encodings and constants for the CD32 riser punt responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riser_spi_reply_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_REPLY   = 2'd2;

    localparam logic [7:0] REPLY_CMD_DEF      = 8'hA5;
    localparam int         TIMEOUT_CYCLES_DEF = 1024;
    localparam int         SYNC_STAGES_DEF    = 2;

    // REQ_TAG layout: {RW, type[1:0], A[5:1]}
    localparam int TAG_RW      = 7;
    localparam int TAG_TYPE_HI = 6;
    localparam int TAG_TYPE_LO = 5;
    localparam int TAG_ADDR_HI = 4;
    localparam int TAG_ADDR_LO = 0;

    localparam logic [7:0] TIMEOUT_REPLY = 8'hFF;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] data;
    } spi_frame_t;

    function automatic logic [15:0] miso_word(input logic pending, input logic [7:0] tag);
        return {pending, 7'b0, tag};
    endfunction

endpackage

`default_nettype wire

// File: rtl/riser_spi_reply_if.sv
// ============================================================================
// Module  : riser_spi_reply_if
// Brief   : 68020 bus, punt request and SPI signals of the riser responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface riser_spi_reply_if;
    logic       AS20;
    logic       DS20;
    logic       RW;
    logic       REQ_VALID;
    logic [7:0] REQ_TAG;
    logic       SPI_NSS;
    logic       SPI_CK;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic [7:0] D_OUT;
    logic       D_OE;
    logic       ACK;

    modport slave (
        input  AS20, DS20, RW, REQ_VALID, REQ_TAG, SPI_NSS, SPI_CK, SPI_MOSI,
        output SPI_MISO, D_OUT, D_OE, ACK
    );

    modport master (
        output AS20, DS20, RW, REQ_VALID, REQ_TAG, SPI_NSS, SPI_CK, SPI_MOSI,
        input  SPI_MISO, D_OUT, D_OE, ACK
    );
endinterface

`default_nettype wire

// File: rtl/riser_spi_shifter.sv
// ============================================================================
// Module  : riser_spi_shifter
// Brief   : SPI mode-0 slave shifter: synchronisers, edge detect, 16-bit frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riser_spi_shifter
    import riser_spi_reply_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  wire logic        CLKCPU_A,
    input  wire logic        RESET_n,
    input  wire logic        spi_nss_i,
    input  wire logic        spi_ck_i,
    input  wire logic        spi_mosi_i,
    input  wire logic [15:0] miso_word_i,
    output logic             spi_miso_o,
    output logic             frame_done_o,
    output spi_frame_t       frame_o
);

    logic [SYNC_STAGES-1:0] nss_sync_q;
    logic [SYNC_STAGES-1:0] ck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   nss_prev_q;
    logic                   ck_prev_q;
    logic [4:0]             bit_cnt_q;
    logic [14:0]            rx_q;
    logic [15:0]            tx_q;

    logic w_nss, w_ck, w_mosi;
    logic w_ck_rise, w_ck_fall, w_nss_fall;

    assign w_nss      = nss_sync_q[SYNC_STAGES-1];
    assign w_ck       = ck_sync_q[SYNC_STAGES-1];
    assign w_mosi     = mosi_sync_q[SYNC_STAGES-1];
    assign w_ck_rise  =  w_ck & ~ck_prev_q;
    assign w_ck_fall  = ~w_ck &  ck_prev_q;
    assign w_nss_fall = ~w_nss & nss_prev_q;

    // NSS synchroniser resets to the deselected level so reset release is not a frame start
    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            nss_sync_q  <= '1;
            ck_sync_q   <= '0;
            mosi_sync_q <= '0;
            nss_prev_q  <= 1'b1;
            ck_prev_q   <= 1'b0;
        end else begin
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss_i};
            ck_sync_q   <= {ck_sync_q[SYNC_STAGES-2:0], spi_ck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            nss_prev_q  <= w_nss;
            ck_prev_q   <= w_ck;
        end
    end

    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            bit_cnt_q <= 5'd0;
            rx_q      <= 15'd0;
        end else if (w_nss) begin
            bit_cnt_q <= 5'd0;
        end else if (w_ck_rise && (bit_cnt_q != 5'd16)) begin
            rx_q      <= {rx_q[13:0], w_mosi};
            bit_cnt_q <= bit_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            tx_q <= 16'd0;
        end else if (w_nss_fall) begin
            tx_q <= miso_word_i;
        end else if (!w_nss && w_ck_fall) begin
            tx_q <= {tx_q[14:0], 1'b0};
        end
    end

    // The 16th bit is taken straight from the synchroniser so the frame is usable in its own cycle
    assign frame_done_o = ~w_nss & w_ck_rise & (bit_cnt_q == 5'd15);
    assign frame_o      = spi_frame_t'({rx_q, w_mosi});
    assign spi_miso_o   = tx_q[15];

endmodule

`default_nettype wire

// File: rtl/riser_spi_reply.sv
// ============================================================================
// Module  : riser_spi_reply
// Brief   : MCU reply responder for punted 68020 cycles on the CD32 riser.
//           Optional PENDING timeout enabled by RISER_REPLY_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riser_spi_reply
    import riser_spi_reply_pkg::*;
#(
    parameter logic [7:0] REPLY_CMD      = REPLY_CMD_DEF,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int         SYNC_STAGES    = SYNC_STAGES_DEF
) (
    input  wire logic      CLKCPU_A,
    input  wire logic      RESET_n,
    riser_spi_reply_if.slave bus
);

    logic [1:0] state_q, state_d;
    logic [7:0] tag_q,   tag_d;
    logic [7:0] dout_q,  dout_d;
    logic       ack_q,   ack_d;

    logic       w_frame_done;
    spi_frame_t w_frame;
    logic       w_commit;
    logic       w_expire;
    logic       w_unused_ok;

    riser_spi_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .CLKCPU_A     (CLKCPU_A),
        .RESET_n      (RESET_n),
        .spi_nss_i    (bus.SPI_NSS),
        .spi_ck_i     (bus.SPI_CK),
        .spi_mosi_i   (bus.SPI_MOSI),
        .miso_word_i  (miso_word(state_q == ST_PENDING, tag_q)),
        .spi_miso_o   (bus.SPI_MISO),
        .frame_done_o (w_frame_done),
        .frame_o      (w_frame)
    );

    assign w_commit = w_frame_done && (w_frame.cmd == REPLY_CMD) && (state_q == ST_PENDING);

`ifdef RISER_REPLY_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Held at zero outside PENDING, so it is already clear on entry
    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ST_PENDING) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign w_expire    = (state_q == ST_PENDING) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_unused_ok = bus.DS20;
`else
    assign w_expire    = 1'b0;
    assign w_unused_ok = bus.DS20 | (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        dout_d  = dout_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_VALID && !bus.AS20) begin
                    tag_d   = bus.REQ_TAG;
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Abort outranks commit, and commit outranks timeout
                if (bus.AS20) begin
                    state_d = ST_IDLE;
                end else if (w_commit) begin
                    dout_d  = w_frame.data;
                    ack_d   = 1'b1;
                    state_d = ST_REPLY;
                end else if (w_expire) begin
                    dout_d  = TIMEOUT_REPLY;
                    ack_d   = 1'b1;
                    state_d = ST_REPLY;
                end
            end
            ST_REPLY: begin
                if (bus.AS20) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= ST_IDLE;
            tag_q   <= 8'h00;
            dout_q  <= 8'h00;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.D_OUT = dout_q;
    assign bus.ACK   = ack_q;
    assign bus.D_OE  = (state_q == ST_REPLY) & ~bus.AS20 & bus.RW & tag_q[TAG_RW];

endmodule

`default_nettype wire

// File: tb/tb_riser_spi_reply.sv
// ============================================================================
// Module  : tb_riser_spi_reply
// Brief   : Scoreboard bench for riser_spi_reply with randomised SPI traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riser_spi_reply;
    import riser_spi_reply_pkg::*;

    localparam int HALF = 60;

    typedef struct {
        logic [7:0] data;
        logic       oe;
    } exp_t;

    typedef struct {
        logic [15:0] w;
        int          n;
    } frm_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riser_spi_reply_if bus ();

    riser_spi_reply #(
        .REPLY_CMD      (8'hA5),
        .TIMEOUT_CYCLES (4000),
        .SYNC_STAGES    (2)
    ) dut (
        .CLKCPU_A (clk),
        .RESET_n  (rst_n),
        .bus      (bus)
    );

`ifdef RISER_REPLY_TIMEOUT_EN
    riser_spi_reply_if tbus ();

    riser_spi_reply #(
        .REPLY_CMD      (8'hA5),
        .TIMEOUT_CYCLES (16),
        .SYNC_STAGES    (2)
    ) dut_tmo (
        .CLKCPU_A (clk),
        .RESET_n  (rst_n),
        .bus      (tbus)
    );
`endif

    int   total    = 0;
    int   bad      = 0;
    int   ack_seen = 0;
    exp_t exp_q[$];
    frm_t frm_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Every ACK pulse must match the oldest outstanding reply
    always @(negedge clk) begin
        exp_t e;
        if (bus.ACK === 1'b1) begin
            ack_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ACK=1 expected no ACK");
            end else begin
                e = exp_q.pop_front();
                check("ack_dout", {24'd0, bus.D_OUT}, {24'd0, e.data});
                check("ack_doe", {31'd0, bus.D_OE}, {31'd0, e.oe});
            end
        end
    end

    task automatic spi_frame(input logic [15:0] mosi, input int nbits, output logic [15:0] miso);
        miso        = 16'd0;
        bus.SPI_NSS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.SPI_MOSI = (i < 16) ? mosi[15 - i] : 1'b1;
            #HALF;
            if (i < 16) miso[15 - i] = bus.SPI_MISO;
            bus.SPI_CK = 1'b1;
            #HALF;
            bus.SPI_CK = 1'b0;
        end
        #HALF;
        bus.SPI_NSS = 1'b1;
        #(2 * HALF);
    endtask

    // Model: the first complete frame carrying A5 while the request is held is the reply
    task automatic run_txn(input logic [7:0] tag, input logic rw, input bit keep);
        logic [15:0] miso;
        int          base;
        bit          committed;
        bit          hit;
        exp_t        e;
        base      = ack_seen;
        committed = 1'b0;
        e.data    = 8'h00;
        e.oe      = 1'b0;
        @(negedge clk);
        bus.REQ_TAG   = tag;
        bus.RW        = rw;
        bus.AS20      = 1'b0;
        bus.DS20      = 1'b0;
        bus.REQ_VALID = 1'b1;
        repeat (3) @(negedge clk);
        foreach (frm_q[k]) begin
            hit = !committed && (frm_q[k].n >= 16) && (frm_q[k].w[15:8] == 8'hA5);
            if (hit) begin
                e.data = frm_q[k].w[7:0];
                e.oe   = rw & tag[7];
                exp_q.push_back(e);
            end
            spi_frame(frm_q[k].w, frm_q[k].n, miso);
            if ((frm_q[k].n >= 16) && !committed)
                check("miso_word", {16'd0, miso}, {16'd0, 8'h80, tag});
            if (hit) committed = 1'b1;
        end
        check("ack_count", ack_seen - base, committed ? 1 : 0);
        if (committed) begin
            @(negedge clk);
            check("doe_hold", {31'd0, bus.D_OE}, {31'd0, e.oe});
            check("dout_hold", {24'd0, bus.D_OUT}, {24'd0, e.data});
        end
        if (!keep) begin
            bus.AS20 = 1'b1;
            bus.DS20 = 1'b1;
            #1;
            check("doe_release", {31'd0, bus.D_OE}, 32'd0);
            bus.REQ_VALID = 1'b0;
            repeat (4) @(negedge clk);
        end
        frm_q.delete();
    endtask

    function automatic frm_t mk(input logic [7:0] c, input logic [7:0] d, input int n);
        frm_t f;
        f.w = {c, d};
        f.n = n;
        return f;
    endfunction

    initial begin
        logic [15:0] miso;
        logic [7:0]  tag;
        logic [7:0]  c;
        int          base;
        int          nbad;
        bus.AS20      = 1'b1;
        bus.DS20      = 1'b1;
        bus.RW        = 1'b1;
        bus.REQ_VALID = 1'b0;
        bus.REQ_TAG   = 8'h00;
        bus.SPI_NSS   = 1'b1;
        bus.SPI_CK    = 1'b0;
        bus.SPI_MOSI  = 1'b0;
`ifdef RISER_REPLY_TIMEOUT_EN
        tbus.AS20      = 1'b1;
        tbus.DS20      = 1'b1;
        tbus.RW        = 1'b1;
        tbus.REQ_VALID = 1'b0;
        tbus.REQ_TAG   = 8'h00;
        tbus.SPI_NSS   = 1'b1;
        tbus.SPI_CK    = 1'b0;
        tbus.SPI_MOSI  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_dout", {24'd0, bus.D_OUT}, 32'd0);
        check("rst_outs", {29'd0, bus.D_OE, bus.ACK, bus.SPI_MISO}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Read, then write
        frm_q.push_back(mk(8'hA5, 8'h3C, 16));
        run_txn(8'h81, 1'b1, 1'b0);
        frm_q.push_back(mk(8'hA5, 8'h00, 16));
        run_txn(8'h01, 1'b0, 1'b0);

        // Wrong command, short frame, then a real reply
        frm_q.push_back(mk(8'h5A, 8'h3C, 16));
        frm_q.push_back(mk(8'hA5, 8'h55, 9));
        frm_q.push_back(mk(8'hA5, 8'h77, 16));
        run_txn(8'h83, 1'b1, 1'b0);

        for (int t = 0; t < 12; t++) begin
            tag  = 8'($urandom);
            nbad = $urandom_range(0, 2);
            for (int b = 0; b < nbad; b++) begin
                if ($urandom_range(0, 1) == 0) begin
                    c = 8'($urandom);
                    if (c == 8'hA5) c = 8'h5A;
                    frm_q.push_back(mk(c, 8'($urandom), 16));
                end else begin
                    frm_q.push_back(mk(8'hA5, 8'($urandom), $urandom_range(1, 15)));
                end
            end
            frm_q.push_back(mk(8'hA5, 8'($urandom), 16 + $urandom_range(0, 3)));
            run_txn(tag, ($urandom_range(0, 3) == 0) ? ~tag[7] : tag[7], 1'b0);
        end

        // Abort while PENDING, then a late reply frame
        base = ack_seen;
        @(negedge clk);
        bus.REQ_TAG   = 8'h85;
        bus.RW        = 1'b1;
        bus.AS20      = 1'b0;
        bus.REQ_VALID = 1'b1;
        repeat (5) @(negedge clk);
        bus.AS20      = 1'b1;
        bus.REQ_VALID = 1'b0;
        repeat (3) @(negedge clk);
        spi_frame(16'hA512, 16, miso);
        check("abort_status", {31'd0, miso[15]}, 32'd0);
        check("abort_ack", ack_seen - base, 0);
        check("abort_doe", {31'd0, bus.D_OE}, 32'd0);

        // No SPI traffic while PENDING on the long-timeout instance
        base = ack_seen;
        @(negedge clk);
        bus.AS20      = 1'b0;
        bus.REQ_VALID = 1'b1;
        repeat (2000) @(negedge clk);
        check("no_timeout_ack", ack_seen - base, 0);
        bus.AS20      = 1'b1;
        bus.REQ_VALID = 1'b0;
        repeat (3) @(negedge clk);

`ifdef RISER_REPLY_TIMEOUT_EN
        begin
            int n;
            @(negedge clk);
            tbus.REQ_TAG   = 8'h81;
            tbus.RW        = 1'b1;
            tbus.AS20      = 1'b0;
            tbus.REQ_VALID = 1'b1;
            @(posedge clk);
            n = 1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (tbus.ACK === 1'b1) break;
                @(posedge clk);
                n++;
            end
            check("tmo_cycle", n, 17);
            check("tmo_dout", {24'd0, tbus.D_OUT}, 32'hFF);
            check("tmo_doe", {31'd0, tbus.D_OE}, 32'd1);
            tbus.AS20      = 1'b1;
            tbus.REQ_VALID = 1'b0;
            repeat (3) @(negedge clk);
        end
`endif

        // Reset mid-frame while in REPLY
        frm_q.push_back(mk(8'hA5, 8'h5A, 16));
        run_txn(8'h81, 1'b1, 1'b1);
        bus.SPI_NSS = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.SPI_MOSI = 1'b1;
            #HALF;
            bus.SPI_CK = 1'b1;
            #HALF;
            bus.SPI_CK = 1'b0;
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout", {24'd0, bus.D_OUT}, 32'd0);
        check("mid_rst_outs", {29'd0, bus.D_OE, bus.ACK, bus.SPI_MISO}, 32'd0);
        bus.SPI_NSS   = 1'b1;
        bus.AS20      = 1'b1;
        bus.REQ_VALID = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        frm_q.push_back(mk(8'hA5, 8'hC3, 16));
        run_txn(8'h9E, 1'b1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
